// File: rtl/aes_inv_cipher_ctrl_pkg.sv
// rtl/aes_inv_cipher_ctrl_pkg.sv - shared types and helpers for the AES inverse cipher flow controller
// Contents:
//   AES_NK_DEFAULT  default key length in 32-bit words
//   AES_TAG_W       default sideband tag width
//   aes_tag_t       tag type at the default width
//   aes_nr(nk)      round count for a given key length
package aes_inv_cipher_ctrl_pkg;

  localparam int AES_NK_DEFAULT = 4;
  localparam int AES_TAG_W      = 4;

  typedef logic [AES_TAG_W-1:0] aes_tag_t;

  function automatic int aes_nr(input int nk);
    return nk + 6;
  endfunction

endpackage

// File: rtl/aes_inv_cipher_ctrl_if.sv
// rtl/aes_inv_cipher_ctrl_if.sv - ready/valid block stream in and out of the inverse cipher pipe
// Signals:
//   in_valid / in_ready / in_tag    ciphertext block offered to the pipe
//   out_valid / out_ready / out_tag plaintext block leaving the pipe
// Modports:
//   master  producer of input blocks and consumer of output blocks
//   slave   the flow controller
interface aes_inv_cipher_ctrl_if #(
  parameter int TAG_W = 4
);

  logic             in_valid;
  logic             in_ready;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid,
    input  in_ready,
    output in_tag,
    input  out_valid,
    output out_ready,
    input  out_tag
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_tag,
    output out_valid,
    input  out_ready,
    output out_tag
  );

endinterface

// File: rtl/aes_inv_cipher_ctrl_pipe_slot_ctl.sv
// rtl/aes_inv_cipher_ctrl_pipe_slot_ctl.sv - occupancy bit, tag register and load enable for one pipe stage
// Ports:
//   clk, rst_n  clock and async active-low reset
//   flush       discard the block held here on the next edge
//   up_occ      upstream stage (or input) holds a block ready to move in
//   up_tag      tag travelling with that block
//   drain       the block held here leaves on this edge
//   occ         this stage holds a block
//   tag         tag of the block held here
//   en          load enable for this stage
module aes_inv_cipher_ctrl_pipe_slot_ctl #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             up_occ,
  input  logic [TAG_W-1:0] up_tag,
  input  logic             drain,
  output logic             occ,
  output logic [TAG_W-1:0] tag,
  output logic             en
);

  logic acc;

  // A slot can take a new block when it is empty or its current block is
  // leaving on the same edge; this is what lets bubbles collapse.
  assign acc = !occ || drain;
  assign en  = up_occ && acc && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ <= 1'b0;
      tag <= '0;
    end else if (flush) begin
      occ <= 1'b0;
    end else if (en) begin
      occ <= 1'b1;
      tag <= up_tag;
    end else if (drain) begin
      occ <= 1'b0;
    end
  end

endmodule

// File: rtl/aes_inv_cipher_ctrl.sv
// rtl/aes_inv_cipher_ctrl.sv - flow controller for the Nr+1 stage pipelined AES inverse cipher
// Ports:
//   clk, rst_n  clock and async active-low reset
//   bus         slave side of the input/output block stream
//   flush       synchronous discard of every in-flight block
//   stage_en    load enable per datapath stage, index Nr (input side) .. 0 (output side)
//   inflight    number of occupied stages
//   busy        inflight != 0
module aes_inv_cipher_ctrl
  import aes_inv_cipher_ctrl_pkg::*;
#(
  parameter int Nk    = AES_NK_DEFAULT,
  parameter int Nr    = aes_nr(Nk),
  parameter int TAG_W = AES_TAG_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  aes_inv_cipher_ctrl_if.slave     bus,
  input  logic                     flush,
  output logic [0:Nr]              stage_en,
  output logic [$clog2(Nr+2)-1:0]  inflight,
  output logic                     busy
);

  localparam int CNT_W = $clog2(Nr + 2);

  logic             out_valid_w;
  logic             deliver;
  logic [CNT_W-1:0] inflight_q;

  // Blocks move from stage i+1 to stage i. The drain of stage i is the load
  // enable of stage i-1, so the ready path ripples from the output back to
  // the input within one cycle to sustain one block per cycle.
  for (genvar i = 0; i <= Nr; i++) begin : g_slot
    logic             drain;
    logic             up_occ;
    logic [TAG_W-1:0] up_tag;
    logic             occ;
    logic [TAG_W-1:0] tag;
    logic             en;

    if (i == 0) begin : g_drain_out
      assign drain = bus.out_ready;
    end else begin : g_drain_chain
      assign drain = g_slot[i-1].en;
    end

    if (i == Nr) begin : g_up_in
      assign up_occ = bus.in_valid;
      assign up_tag = bus.in_tag;
    end else begin : g_up_stage
      assign up_occ = g_slot[i+1].occ;
      assign up_tag = g_slot[i+1].tag;
    end

    aes_inv_cipher_ctrl_pipe_slot_ctl #(
      .TAG_W (TAG_W)
    ) u_slot (
      .clk    (clk),
      .rst_n  (rst_n),
      .flush  (flush),
      .up_occ (up_occ),
      .up_tag (up_tag),
      .drain  (drain),
      .occ    (occ),
      .tag    (tag),
      .en     (en)
    );

    assign stage_en[i] = en;
  end

  assign out_valid_w  = g_slot[0].occ;
  assign bus.out_valid = out_valid_w;
  assign bus.out_tag   = g_slot[0].tag;
  assign bus.in_ready  = (!g_slot[Nr].occ || g_slot[Nr].drain) && !flush;

  assign deliver = out_valid_w && bus.out_ready;

  // Tracks occupancy without summing occ bits: +1 per accept, -1 per delivery.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= '0;
    end else if (flush) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_q + CNT_W'(stage_en[Nr]) - CNT_W'(deliver);
    end
  end

  assign inflight = inflight_q;
  assign busy     = (inflight_q != '0);

endmodule
